// File: rtl/fp32_stream_accum.sv
// Handshaked FP32 stream accumulator around a combinational IEEE-754 adder.
// Sums len operands, each optionally negated, and then presents the result until it is taken.

module fpadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s
);
  localparam int unsigned EXT_W = 27;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  // Leading-zero count over the 27-bit extended magnitude
  function automatic logic [4:0] clz27(input logic [EXT_W-1:0] v);
    clz27 = 5'd27;
    for (int i = 0; i < EXT_W; i++) begin
      if (v[i]) clz27 = 5'(EXT_W - 1 - i);
    end
  endfunction

  logic              sa, sb;
  logic [7:0]        ea, eb, ea_eff, eb_eff;
  logic [22:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic              a_big, s_big, s_sml, eff_sub;
  logic [7:0]        e_big, e_sml, diff, lim, shamt;
  logic [23:0]       m_big, m_sml;
  logic [EXT_W-1:0]  big_ext, sml_ext, sml_shr, sml_al, norm;
  logic              sticky, round_up, inc;
  logic [EXT_W:0]    sum;
  logic [4:0]        lz;
  logic [8:0]        exp_n, exp_field, exp_fin;
  logic [24:0]       mant_r;

  assign sa = a[31];
  assign sb = b[31] ^ sub;
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];
  assign a_nan = (&ea) && (|fa);
  assign b_nan = (&eb) && (|fb);
  assign a_inf = (&ea) && !(|fa);
  assign b_inf = (&eb) && !(|fb);
  // Subnormals share the minimum exponent with a cleared hidden bit
  assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
  assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
  assign a_big  = (a[30:0] >= b[30:0]);

  always_comb begin
    s_big   = a_big ? sa : sb;
    s_sml   = a_big ? sb : sa;
    e_big   = a_big ? ea_eff : eb_eff;
    e_sml   = a_big ? eb_eff : ea_eff;
    m_big   = a_big ? {(ea != 8'd0), fa} : {(eb != 8'd0), fb};
    m_sml   = a_big ? {(eb != 8'd0), fb} : {(ea != 8'd0), fa};
    eff_sub = s_big ^ s_sml;
    diff    = e_big - e_sml;

    big_ext = {m_big, 3'b000};
    sml_ext = {m_sml, 3'b000};
    sml_shr = sml_ext >> diff;
    sticky  = (diff >= 8'd27) ? (|sml_ext)
                              : (|(sml_ext & ((27'd1 << diff) - 27'd1)));
    sml_al  = {sml_shr[EXT_W-1:1], sml_shr[0] | sticky};

    sum = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_al})
                  : ({1'b0, big_ext} + {1'b0, sml_al});

    lz    = clz27(sum[EXT_W-1:0]);
    lim   = e_big - 8'd1;
    shamt = 8'd0;
    norm  = '0;
    exp_n = '0;
    if (sum[EXT_W]) begin
      norm  = {sum[EXT_W:2], sum[1] | sum[0]};
      exp_n = {1'b0, e_big} + 9'd1;
    end else begin
      // Stop normalising at the minimum exponent so tiny results stay subnormal
      shamt = (8'(lz) > lim) ? lim : 8'(lz);
      norm  = sum[EXT_W-1:0] << shamt;
      exp_n = {1'b0, e_big} - 9'(shamt);
    end

    exp_field = norm[EXT_W-1] ? exp_n : 9'd0;
    round_up  = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r    = {1'b0, norm[EXT_W-1:3]} + 25'(round_up);
    inc       = mant_r[24] || (!norm[EXT_W-1] && mant_r[23]);
    exp_fin   = exp_field + 9'(inc);

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s = QNAN;
    end else if (a_inf) begin
      s = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      s = {sb, 8'hFF, 23'd0};
    end else if (sum == '0) begin
      s = {(!eff_sub) && s_big, 31'd0};
    end else if (exp_fin >= 9'd255) begin
      s = {s_big, 8'hFF, 23'd0};
    end else begin
      s = {s_big, exp_fin[7:0], mant_r[22:0]};
    end
  end
endmodule

module fp32_stream_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      add_s;
  logic [31:0]      first_w;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] len_q;

  fpadder u_add (
    .a   (acc),
    .b   (in_data),
    .sub (in_neg),
    .s   (add_s)
  );

  // First beat loads the operand directly so no add against zero occurs
  assign first_w  = {in_data[31] ^ in_neg, in_data[30:0]};
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign out_data = acc;

  // Status outputs are flops that move with the state, so they decode nothing combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 32'h0;
      cnt       <= '0;
      len_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= 32'h0;
            busy  <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= ACC;
              in_ready <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= (cnt == '0) ? first_w : add_s;
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_stream_accum.sv
// Directed bench for fp32_stream_accum: sums, negation, zero length, gaps, backpressure, reset.
module tb_fp32_stream_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fp32_stream_accum #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic n);
    in_valid = 1'b1;
    in_data  = d;
    in_neg   = n;
    step();
    in_valid = 1'b0;
    in_neg   = 1'b0;
  endtask

  task automatic kick(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_neg = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_busy",      32'(busy),      32'd0);

    // 1 + 2 + 3 = 6
    kick(8'd3);
    chk("sum_in_ready", 32'(in_ready), 32'd1);
    chk("sum_busy",     32'(busy),     32'd1);
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    chk("sum_busy_mid",      32'(busy),      32'd1);
    chk("sum_not_done_early",32'(out_valid), 32'd0);
    beat(32'h4040_0000, 1'b0);
    chk("sum_out_valid", 32'(out_valid), 32'd1);
    chk("sum_out_data",  out_data,       32'h40C0_0000);
    chk("sum_in_ready_done", 32'(in_ready), 32'd0);
    chk("sum_busy_done", 32'(busy),      32'd1);
    release_result();
    chk("sum_valid_drop", 32'(out_valid), 32'd0);
    chk("sum_busy_drop",  32'(busy),      32'd0);

    // -5 - 2 = -7, first beat negated by sign flip
    kick(8'd2);
    beat(32'h40A0_0000, 1'b1);
    chk("neg_first", out_data, 32'hC0A0_0000);
    beat(32'h4000_0000, 1'b1);
    chk("neg_out_valid", 32'(out_valid), 32'd1);
    chk("neg_out_data",  out_data,       32'hC0E0_0000);
    release_result();

    // Zero length completes the cycle after start with a cleared accumulator
    kick(8'd0);
    chk("zero_out_valid", 32'(out_valid), 32'd1);
    chk("zero_out_data",  out_data,       32'h0);
    chk("zero_in_ready",  32'(in_ready),  32'd0);
    release_result();

    // Input gap then output backpressure
    kick(8'd2);
    beat(32'h3F80_0000, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("gap_out_valid", 32'(out_valid), 32'd0);
    chk("gap_in_ready",  32'(in_ready),  32'd1);
    chk("gap_acc_hold",  out_data,       32'h3F80_0000);
    beat(32'h3F80_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  out_data,       32'h4000_0000);
      step();
    end
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    release_result();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);

    // start while busy must be ignored
    kick(8'd3);
    beat(32'h3F80_0000, 1'b0);
    kick(8'd1);
    chk("busy_start_in_ready", 32'(in_ready),  32'd1);
    chk("busy_start_no_done",  32'(out_valid), 32'd0);
    chk("busy_start_acc",      out_data,       32'h3F80_0000);
    beat(32'h4000_0000, 1'b0);
    chk("busy_start_two_beats", 32'(out_valid), 32'd0);
    beat(32'h4040_0000, 1'b0);
    chk("busy_start_valid", 32'(out_valid), 32'd1);
    chk("busy_start_data",  out_data,       32'h40C0_0000);
    // start coinciding with the release handshake is also ignored
    start = 1'b1; len = 8'd0; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("release_start_valid", 32'(out_valid), 32'd0);
    chk("release_start_busy",  32'(busy),      32'd0);

    // Cancellation and round-to-nearest-even ties
    kick(8'd2);
    beat(32'h3F80_0000, 1'b0);
    beat(32'h3F80_0000, 1'b1);
    chk("cancel_data", out_data, 32'h0);
    release_result();
    kick(8'd2);
    beat(32'h3F80_0000, 1'b0);
    beat(32'h3380_0000, 1'b0);
    chk("tie_even_down", out_data, 32'h3F80_0000);
    release_result();
    kick(8'd2);
    beat(32'h3F80_0001, 1'b0);
    beat(32'h3380_0000, 1'b0);
    chk("tie_odd_up", out_data, 32'h3F80_0002);
    release_result();

    // Reset mid-stream aborts, then a fresh single-beat stream
    kick(8'd4);
    beat(32'h3F80_0000, 1'b0);
    beat(32'h3F80_0000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data",  out_data,       32'h0);
    kick(8'd1);
    beat(32'h3F80_0000, 1'b0);
    chk("fresh_out_valid", 32'(out_valid), 32'd1);
    chk("fresh_out_data",  out_data,       32'h3F80_0000);
    release_result();
    chk("fresh_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
